// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: default widths and the
// encoding of the transmit-offer register.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_DEPTH_LOG2 = 4;

  // Offer register: WAIT = nothing presented, OFFER = head byte presented.
  typedef enum logic {
    ST_WAIT  = 1'b0,
    ST_OFFER = 1'b1
  } offer_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one
// asynchronous read port feeding the serializer's data input directly.
module uart_fifo_mem #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the entry addressed by the write pointer on an accepted push.
  // NOTE: storage is deliberately not reset; level/pointers decide what is
  // valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO in front of the TX UART serializer. Bytes enter through a
// valid/ready handshake; the head byte is offered with a level-held
// uart_valid and popped on the serializer's one-cycle frame-done pulse.
// Optional build macro UART_TX_FIFO_CTS_EN adds a cts_n input (two-flop
// synchronized) that gates new offers, plus a cts_stalled status output.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = UART_DEPTH_LOG2,
  parameter int DATA_W     = UART_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef UART_TX_FIFO_CTS_EN
  input  logic                  cts_n,
  output logic                  cts_stalled,
`endif
  input  logic                  wr_valid,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_ready,
  input  logic                  flush,
  output logic                  uart_valid,
  output logic [DATA_W-1:0]     uart_data,
  input  logic                  uart_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  idle
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  offer_state_e          state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  push, pop, send_ok;

  // Status is derived from the registered level, so wr_ready is a clean
  // registered !full and a push into a full FIFO is refused even if a pop
  // happens in the same cycle.
  assign full       = (level_q == LVL_FULL);
  assign empty      = (level_q == '0);
  assign wr_ready   = !full;
  assign uart_valid = (state_q == ST_OFFER);
  assign idle       = empty & !uart_valid;
  assign level      = level_q;

  // flush discards the not-yet-started bytes, so it also drops a same-cycle push.
  assign push = wr_valid & wr_ready & !flush;
  assign pop  = uart_ready & uart_valid;

`ifdef UART_TX_FIFO_CTS_EN
  logic [1:0] cts_sync;

  // Two-flop synchronizer for the asynchronous clear-to-send; resets to
  // "not clear" so nothing is offered until the peer is seen ready.
  always_ff @(posedge clk) begin
    if (reset) cts_sync <= 2'b11;
    else       cts_sync <= {cts_sync[0], cts_n};
  end

  assign send_ok     = !cts_sync[1];
  assign cts_stalled = !empty & !uart_valid & cts_sync[1];
`else
  assign send_ok = 1'b1;
`endif

  // State register for the offer flag, pointers and level counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_WAIT;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr  <= wr_ptr_d;
      rd_ptr  <= rd_ptr_d;
      level_q <= level_d;
    end
  end

  // Next-state logic: pointer/level bookkeeping and the WAIT/OFFER decision.
  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    level_d  = level_q;

    if (pop) rd_ptr_d = rd_ptr + PTR_ONE;

    if (flush) begin
      if (uart_valid) begin
        // Keep the in-flight head; a concurrent pop retires it as well.
        wr_ptr_d = rd_ptr + PTR_ONE;
        level_d  = pop ? '0 : LVL_ONE;
      end else begin
        wr_ptr_d = rd_ptr;
        level_d  = '0;
      end
    end else begin
      if (push) wr_ptr_d = wr_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end

    case (state_q)
      // A flush in WAIT empties the queue, so it must not start an offer.
      ST_WAIT:  if (level_q != '0 && !flush && send_ok) state_d = ST_OFFER;
      // Once offered, the frame is held until the serializer takes it.
      ST_OFFER: if (uart_ready) state_d = ST_WAIT;
      default:  state_d = ST_WAIT;
    endcase
  end

  uart_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (uart_data)
  );

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a reset check, a table of directed
// vectors, hand-written corner sequences, then randomized traffic compared
// against a queue-based reference model.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_ready;
  logic       flush = 1'b0;
  logic       uart_valid;
  logic [7:0] uart_data;
  logic       uart_ready = 1'b0;
  logic [4:0] level;
  logic       empty, full, idle;
`ifdef UART_TX_FIFO_CTS_EN
  logic       cts_n = 1'b0;
  logic       cts_stalled;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the queued bytes (head first), whether the head is
  // currently offered, and the two synchronizer stages of cts_n.
  logic [7:0] mq[$];
  bit         m_valid;
  bit         s1 = 1'b1, s2 = 1'b1;

  uart_tx_fifo #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef UART_TX_FIFO_CTS_EN
    .cts_n      (cts_n),
    .cts_stalled(cts_stalled),
`endif
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .flush      (flush),
    .uart_valid (uart_valid),
    .uart_data  (uart_data),
    .uart_ready (uart_ready),
    .level      (level),
    .empty      (empty),
    .full       (full),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("m_level",      32'(level),      32'(mq.size()));
    check("m_empty",      32'(empty),      32'(mq.size() == 0));
    check("m_full",       32'(full),       32'(mq.size() == DEPTH));
    check("m_wr_ready",   32'(wr_ready),   32'(mq.size() < DEPTH));
    check("m_uart_valid", 32'(uart_valid), 32'(m_valid));
    check("m_idle",       32'(idle),       32'(mq.size() == 0 && !m_valid));
    if (m_valid) check("m_uart_data", 32'(uart_data), 32'(mq[0]));
`ifdef UART_TX_FIFO_CTS_EN
    check("m_cts_stalled", 32'(cts_stalled), 32'(mq.size() != 0 && !m_valid && s2));
`endif
  endtask

  // One clock of stimulus: drive inputs, take the edge, advance the model
  // from pre-edge values, then compare all outputs 1 time unit later.
  task automatic apply(input bit wv, input logic [7:0] wd, input bit fl, input bit rdy);
    bit         do_pop, do_push, cts_ok;
    int         sz;
    logic [7:0] head;
    wr_valid = wv; wr_data = wd; flush = fl; uart_ready = rdy;
    sz      = mq.size();
    cts_ok  = 1'b1;
`ifdef UART_TX_FIFO_CTS_EN
    cts_ok  = !s2;
`endif
    do_pop  = rdy && m_valid;
    do_push = wv && (sz < DEPTH) && !fl;
    @(posedge clk);
    if (fl) begin
      if (m_valid) begin
        head = mq[0];
        mq.delete();
        mq.push_back(head);
      end else begin
        mq.delete();
      end
      if (do_pop) void'(mq.pop_front());
    end else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(wd);
    end
    if (do_pop) m_valid = 1'b0;
    else if (!m_valid && sz != 0 && !fl && cts_ok) m_valid = 1'b1;
`ifdef UART_TX_FIFO_CTS_EN
    s2 = s1;
    s1 = cts_n;
`endif
    #1;
    check_model();
  endtask

  task automatic do_reset(input bit wv);
    reset = 1'b1; wr_valid = wv; wr_data = 8'hEE; flush = 1'b0; uart_ready = 1'b0;
    @(posedge clk);
    mq.delete(); m_valid = 1'b0; s1 = 1'b1; s2 = 1'b1;
    #1;
    reset = 1'b0; wr_valid = 1'b0;
    check("rst_level",      32'(level),      0);
    check("rst_uart_valid", 32'(uart_valid), 0);
    check("rst_wr_ready",   32'(wr_ready),   1);
    check("rst_empty",      32'(empty),      1);
    check("rst_full",       32'(full),       0);
    check("rst_idle",       32'(idle),       1);
  endtask

  task automatic drain();
    int budget = 200;
    while ((mq.size() != 0 || m_valid) && budget > 0) begin
      apply(1'b0, 8'h00, 1'b0, m_valid);
      budget--;
    end
    check("drain_level", 32'(level), 0);
  endtask

  typedef struct {
    bit         wv;
    logic [7:0] wd;
    bit         fl;
    bit         rdy;
    int         exp_level;
    bit         exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[6];

  initial begin
    // Push 0x55 into an empty FIFO: level at N, valid at N+1, hold, pop.
    tbl[0] = '{1'b1, 8'h55, 1'b0, 1'b0, 1, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 8'h55};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 8'h55};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 8'h55};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00};

    repeat (2) @(posedge clk);
    do_reset(1'b0);

    for (int i = 0; i < 6; i++) begin
      apply(tbl[i].wv, tbl[i].wd, tbl[i].fl, tbl[i].rdy);
      check($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].exp_level));
      check($sformatf("tbl%0d_valid", i), 32'(uart_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) check($sformatf("tbl%0d_data", i), 32'(uart_data), 32'(tbl[i].exp_data));
    end
    check("tbl_idle", 32'(idle), 1);

    // Fill to 16 without ready; 17th push with a concurrent pop is refused.
    for (int i = 0; i < DEPTH; i++) apply(1'b1, 8'(i), 1'b0, 1'b0);
    check("full_flag",     32'(full),      1);
    check("full_wr_ready", 32'(wr_ready),  0);
    check("full_level",    32'(level),     16);
    check("full_head",     32'(uart_data), 0);
    apply(1'b1, 8'h99, 1'b0, 1'b1);
    check("refused_level", 32'(level), 15);
    for (int i = 1; i < DEPTH; i++) begin
      apply(1'b0, 8'h00, 1'b0, 1'b0);
      check($sformatf("order%0d", i), 32'(uart_data), 32'(i));
      apply(1'b0, 8'h00, 1'b0, 1'b1);
    end
    check("order_idle", 32'(idle), 1);

    // uart_ready while nothing is offered is ignored.
    apply(1'b1, 8'h33, 1'b0, 1'b0);
    apply(1'b0, 8'h00, 1'b0, 1'b1);
    check("rdy_ignored_level", 32'(level), 1);
    check("rdy_ignored_valid", 32'(uart_valid), 1);
    drain();

    // flush while 0xA1 is offered keeps only the head.
    apply(1'b1, 8'hA1, 1'b0, 1'b0);
    apply(1'b1, 8'hA2, 1'b0, 1'b0);
    apply(1'b1, 8'hA3, 1'b0, 1'b0);
    apply(1'b0, 8'h00, 1'b1, 1'b0);
    check("flush_level", 32'(level),      1);
    check("flush_valid", 32'(uart_valid), 1);
    check("flush_head",  32'(uart_data),  32'hA1);
    apply(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 8'h00, 1'b0, 1'b0);
      check("flush_no_more", 32'(uart_valid), 0);
    end

    // Simultaneous push and pop at level 3.
    apply(1'b1, 8'h10, 1'b0, 1'b0);
    apply(1'b1, 8'h20, 1'b0, 1'b0);
    apply(1'b1, 8'h30, 1'b0, 1'b0);
    apply(1'b1, 8'h77, 1'b0, 1'b1);
    check("pushpop_level", 32'(level), 3);
    apply(1'b0, 8'h00, 1'b0, 1'b0);
    check("pushpop_next", 32'(uart_data), 32'h20);
    drain();

    // Reset in the middle of an offer, with a push pending.
    apply(1'b1, 8'h5A, 1'b0, 1'b0);
    apply(1'b0, 8'h00, 1'b0, 1'b0);
    do_reset(1'b1);

`ifdef UART_TX_FIFO_CTS_EN
    // Clear-to-send gating: no offer while cts_n is high, three-edge
    // latency after it drops, and no withdrawal once offered.
    cts_n = 1'b1;
    repeat (3) apply(1'b0, 8'h00, 1'b0, 1'b0);
    apply(1'b1, 8'h42, 1'b0, 1'b0);
    apply(1'b0, 8'h00, 1'b0, 1'b0);
    check("cts_blocked", 32'(uart_valid),  0);
    check("cts_stalled", 32'(cts_stalled), 1);
    cts_n = 1'b0;
    apply(1'b0, 8'h00, 1'b0, 1'b0);
    check("cts_lat1", 32'(uart_valid), 0);
    apply(1'b0, 8'h00, 1'b0, 1'b0);
    check("cts_lat2", 32'(uart_valid), 0);
    apply(1'b0, 8'h00, 1'b0, 1'b0);
    check("cts_lat3", 32'(uart_valid), 1);
    cts_n = 1'b1;
    repeat (2) apply(1'b0, 8'h00, 1'b0, 1'b0);
    check("cts_hold", 32'(uart_valid), 1);
    apply(1'b0, 8'h00, 1'b0, 1'b1);
    check("cts_popped", 32'(uart_valid), 0);
    cts_n = 1'b0;
    repeat (3) apply(1'b0, 8'h00, 1'b0, 1'b0);
`endif

    // Randomized traffic: a slow-drain phase to reach full, then a busier one.
    for (int c = 0; c < 3000; c++) begin
      bit         wv, fl, rdy;
      logic [7:0] wd;
      wv  = ($urandom_range(0, 3) != 0);
      wd  = 8'($urandom);
      fl  = ($urandom_range(0, 39) == 0);
      rdy = (c < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
`ifdef UART_TX_FIFO_CTS_EN
      cts_n = ($urandom_range(0, 7) == 0);
`endif
      apply(wv, wd, fl, rdy);
    end
`ifdef UART_TX_FIFO_CTS_EN
    cts_n = 1'b0;
    repeat (3) apply(1'b0, 8'h00, 1'b0, 1'b0);
`endif
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
